// File: rtl/tick_pulse_gen.sv
// tick_pulse_gen: divides clk down to a 1-cycle tick strobe with
// run/pause, single-step, restart and a fast divide for bench runs.
module tick_pulse_gen #(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1,
  parameter int FAST_DIV = 4,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fast,
  input  logic       step,
  input  logic       restart,
  output logic       tick,
  output logic [7:0] tick_count,
  output logic       running
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  logic [CNT_W-1:0] r_cnt;
  logic             r_step_d;

  logic [CNT_W-1:0] w_div_sel;
  logic [CNT_W-1:0] w_last;
  logic             w_wrap;
  logic             w_step_rise;

  assign w_div_sel   = fast ? CNT_W'(FAST_DIV) : CNT_W'(DIV);
  assign w_last      = w_div_sel - CNT_W'(1);
  // >= so a mid-period switch to fast wraps on the next edge
  assign w_wrap      = (r_cnt >= w_last);
  assign w_step_rise = step & ~r_step_d;

  // step_d resets high so a step held through reset never ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_step_d   <= 1'b1;
      tick       <= 1'b0;
      tick_count <= 8'd0;
      running    <= 1'b0;
    end else begin
      r_step_d <= step;
      running  <= en;
      if (restart) begin
        r_cnt <= '0;
        tick  <= 1'b0;
      end else if (en) begin
        if (w_wrap) begin
          r_cnt      <= '0;
          tick       <= 1'b1;
          tick_count <= tick_count + 8'd1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
          tick  <= 1'b0;
        end
      end else if (w_step_rise) begin
        tick       <= 1'b1;
        tick_count <= tick_count + 8'd1;
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_pulse_gen.sv
// tb_tick_pulse_gen: scoreboard bench, DIV=10, FAST_DIV=4.
// Expected ticks are queued with their cycle and tick_count.
module tb_tick_pulse_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       fast;
  logic       step;
  logic       restart;
  logic       tick;
  logic [7:0] tick_count;
  logic       running;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       m_e;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_count = 8'd0;

  tick_pulse_gen #(
    .CLK_HZ  (10),
    .TICK_HZ (1),
    .FAST_DIV(4),
    .CNT_W   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fast      (fast),
    .step      (step),
    .restart   (restart),
    .tick      (tick),
    .tick_count(tick_count),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // every observed tick must match the head of the queue
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        m_e = sb.pop_front();
        n_tests++;
        if (tick !== 1'b1 || tick_count !== m_e.cnt) begin
          n_fail++;
          $display("FAIL tick_at_%0d: tick=%b count=%0d, want tick=1 count=%0d",
                   cyc, tick, tick_count, m_e.cnt);
        end
      end else if (tick !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_tick_at_%0d: tick=%b, want 0", cyc, tick);
      end
    end
  end

  task automatic expect_tick(input int d);
    exp_count = exp_count + 8'd1;
    sb.push_back('{cyc + d, exp_count});
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; fast = 1'b0; step = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_tick: got %b want 0", tick);
    end
    n_tests++;
    if (tick_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", tick_count);
    end
    n_tests++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL reset_running: got %b want 0", running);
    end
    rst = 1'b0;
    expect_tick(10);
    expect_tick(20);
    expect_tick(30);
    @(negedge clk);
    n_tests++;
    if (running !== 1'b1) begin
      n_fail++; $display("FAIL running_on: got %b want 1", running);
    end
    repeat (29) @(negedge clk);
    n_tests++;
    if (tick_count !== 8'd3) begin
      n_fail++; $display("FAIL normal_count: got %0d want 3", tick_count);
    end
  endtask

  task automatic test_fast();
    repeat (7) @(negedge clk);
    fast = 1'b1;
    expect_tick(1);
    expect_tick(5);
    expect_tick(9);
    repeat (9) @(negedge clk);
    fast = 1'b0;
    n_tests++;
    if (tick_count !== 8'd6) begin
      n_fail++; $display("FAIL fast_count: got %0d want 6", tick_count);
    end
  endtask

  task automatic test_pause();
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL pause_running: got %b want 0", running);
    end
    n_tests++;
    if (tick_count !== exp_count) begin
      n_fail++;
      $display("FAIL pause_count: got %0d want %0d", tick_count, exp_count);
    end
    en = 1'b1;
    expect_tick(5);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_step();
    logic [7:0] base;
    base = exp_count;
    en = 1'b0;
    repeat (2) @(negedge clk);
    step = 1'b1;
    expect_tick(1);
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    step = 1'b1;
    expect_tick(1);
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (tick_count !== base + 8'd2) begin
      n_fail++;
      $display("FAIL step_count: got %0d want %0d", tick_count, base + 8'd2);
    end
    step = 1'b1;
    expect_tick(1);
    repeat (2) @(negedge clk);
    en = 1'b1;
    expect_tick(10);
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic test_restart();
    repeat (9) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    n_tests++;
    if (tick !== 1'b0) begin
      n_fail++; $display("FAIL restart_tick: got %b want 0", tick);
    end
    n_tests++;
    if (tick_count !== exp_count) begin
      n_fail++;
      $display("FAIL restart_count: got %0d want %0d", tick_count, exp_count);
    end
    expect_tick(10);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_wrap_and_async_reset();
    int n;
    n = (exp_count == 8'd0) ? 256 : 256 - int'(exp_count);
    fast = 1'b1;
    step = 1'b1;
    for (int k = 1; k <= n; k++) expect_tick(4 * k);
    repeat (4 * n) @(negedge clk);
    n_tests++;
    if (tick_count !== 8'd0) begin
      n_fail++; $display("FAIL wrap_count: got %0d want 0", tick_count);
    end
    expect_tick(4);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    n_tests++;
    if (tick !== 1'b0) begin
      n_fail++; $display("FAIL async_tick: got %b want 0", tick);
    end
    n_tests++;
    if (tick_count !== 8'd0) begin
      n_fail++; $display("FAIL async_count: got %0d want 0", tick_count);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_count = 8'd0;
    repeat (12) @(negedge clk);
    n_tests++;
    if (tick_count !== 8'd0) begin
      n_fail++; $display("FAIL post_rst_count: got %0d want 0", tick_count);
    end
    n_tests++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_running: got %b want 0", running);
    end
  endtask

  initial begin
    test_reset();
    test_fast();
    test_pause();
    test_step();
    test_restart();
    test_wrap_and_async_reset();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missed_ticks: %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tick_pulse_gen.md
Name: tick_pulse_gen

Overview:
Generates the 1-cycle-wide per-second `tick` strobe consumed by the traffic light controller. It divides the system clock by a parameterised ratio and maintains a free-running tick counter for debug/display. It also provides run/pause, single-step, restart and a fast (test) divide mode, so the downstream FSM can be exercised at bench speed.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
TICK_HZ, 1, tick rate in normal mode; DIV = CLK_HZ/TICK_HZ (must be integer, >= 2)
FAST_DIV, 4, divide ratio when `fast`=1 (>= 2, <= DIV)
CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W >= DIV

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  1 = run prescaler, 0 = pause (counter holds)
fast  in  1  1 = divide by FAST_DIV instead of DIV
step  in  1  synchronous level; rising edge while paused issues one tick
restart  in  1  synchronous; clears prescaler phase
tick  out  1  registered, exactly 1 cycle high per period
tick_count  out  8  number of ticks issued, wraps 255->0
running  out  1  registered copy of en (mirrors mode for status LEDs)

Behaviour:
- Reset (async assert, sync-safe release): cnt=0, tick=0, tick_count=0, running=0, step_d=1. step_d resets to 1 so a `step` held high through reset produces no tick.
- Active divisor: div_sel = fast ? FAST_DIV : DIV, evaluated every cycle.
- Priority per rising edge: restart > run count > step.
- restart=1: cnt<=0, tick<=0. tick_count unchanged. step_d is still updated.
- en=1, restart=0:
  - if cnt >= div_sel-1: tick<=1, cnt<=0, tick_count<=tick_count+1 (mod 256).
  - else: tick<=0, cnt<=cnt+1.
  - The `>=` compare covers a switch to fast mid-period: if cnt is already past FAST_DIV-1, tick is issued on the next edge and the counter wraps.
- en=0, restart=0: cnt holds.
  - If step=1 and step_d=0: tick<=1 and tick_count increments.
  - Otherwise tick<=0.
  - Step has no effect on cnt.
- en=1: step edges are ignored. step_d is still updated every cycle, so releasing pause while step is high issues no tick.
- step_d <= step every cycle (outside reset).
- running <= en every cycle.
- Latency, en held 1 from reset release: cnt counts 0..div_sel-1. tick is high in the cycle after the div_sel-th rising edge, then every div_sel cycles. It is never high for 2 consecutive cycles, since div_sel >= 2.
- Pause/resume preserves phase: remaining cycles to the next tick after resume = (div_sel-1) - cnt + 1.
- Reset mid-period or mid-tick: tick drops immediately (async) and counting restarts from 0.
- No combinational path from any input to tick.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), FAST_DIV=4.
- Reset release, en=1 held -> tick first high after edge 10, then after edges 20, 30; width 1 cycle; tick_count 1,2,3.
- en=1, fast=1 -> period 4 cycles. Set fast=1 when cnt=7 -> tick on next edge, then period 4.
- Pause: en=0 at cnt=5 for 20 cycles -> no tick, cnt holds at 5. Resume -> tick after 5 more edges.
- en=0, step pulsed high for 3 cycles twice -> exactly 2 ticks, each 1 cycle, tick_count +2. Step held high across en 0->1 -> no extra tick.
- restart asserted on the edge where cnt=9 -> no tick; next tick 10 edges after restart deasserts; tick_count unchanged.
- Issue 256 ticks -> tick_count wraps to 0. Assert rst mid-period with step high -> tick=0, tick_count=0 immediately; no tick on release.
